// File: rtl/arm_pkg.sv
// Shared ARM pipeline definitions: word width, bubble encoding, reset PC and
// the fetch FSM state encoding.
package arm_pkg;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] INSTR_NOP    = 32'h0000_0000;
  localparam logic [WORD_W-1:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_e;

  // True when the word index of a byte address lies inside instruction memory.
  function automatic logic pc_in_range(input logic [WORD_W-1:0] pc,
                                       input int unsigned mem_words);
    return {2'b00, pc[WORD_W-1:2]} < mem_words;
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: {pc, instr, valid}. Flush inserts a bubble,
// load captures a fetched word, otherwise the contents are held.
module if_id_reg
  import arm_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic              i_load,
  input  logic [WORD_W-1:0] i_pc,
  input  logic [WORD_W-1:0] i_instr,
  output logic [WORD_W-1:0] o_pc,
  output logic [WORD_W-1:0] o_instr,
  output logic              o_valid
);

  logic [WORD_W-1:0] r_pc;
  logic [WORD_W-1:0] r_instr;
  logic              r_valid;

  always_ff @(posedge i_clk) begin
    if (!i_rst || i_flush) begin
      r_pc    <= '0;
      r_instr <= INSTR_NOP;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_pc    <= i_pc;
      r_instr <= i_instr;
      r_valid <= 1'b1;
    end
  end

  assign o_pc    = r_pc;
  assign o_instr = r_instr;
  assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, fetch FSM (RUN/STALL/FAULT),
// valid-fetch counter and the IF/ID register feeding decode.
module fetch_stage
  import arm_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC  = RESET_PC_DEF,
  parameter int unsigned       MEM_WORDS = 1024
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_freeze,
  input  logic              i_branch_taken,
  input  logic [WORD_W-1:0] i_branch_addr,
  output logic [WORD_W-1:0] o_instr_addr,
  input  logic [WORD_W-1:0] i_instruction,
  output logic [WORD_W-1:0] o_if_id_pc,
  output logic [WORD_W-1:0] o_if_id_instr,
  output logic              o_if_id_valid,
  output logic              o_fetch_fault,
  output logic [WORD_W-1:0] o_fetch_count
);

  fetch_state_e      r_state;
  logic [WORD_W-1:0] r_pc;
  logic [WORD_W-1:0] r_count;
  logic              r_fault;

  logic [WORD_W-1:0] w_pc_next;
  logic [WORD_W-1:0] w_branch_pc;
  logic              w_faulting;
  logic              w_advance;
  logic              w_flush;

  assign w_pc_next   = r_pc + 32'd4;
  assign w_branch_pc = i_branch_addr & ~32'h3;
  // An out-of-range PC never fetches, even if FAULT was not entered through RUN.
  assign w_faulting  = (r_state == ST_FAULT) || !pc_in_range(r_pc, MEM_WORDS);
  assign w_advance   = !i_branch_taken && !w_faulting && !i_freeze;
  assign w_flush     = i_branch_taken || w_faulting;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_pc    <= RESET_PC;
      r_count <= '0;
      r_fault <= 1'b0;
      r_state <= ST_RUN;
    end else if (i_branch_taken) begin
      r_pc    <= w_branch_pc;
      r_state <= pc_in_range(w_branch_pc, MEM_WORDS) ? ST_RUN : ST_FAULT;
    end else if (w_faulting) begin
      r_fault <= 1'b1;
      r_state <= ST_FAULT;
    end else if (i_freeze) begin
      r_state <= ST_STALL;
    end else begin
      r_pc    <= w_pc_next;
      r_count <= r_count + 32'd1;
      r_state <= pc_in_range(w_pc_next, MEM_WORDS) ? ST_RUN : ST_FAULT;
    end
  end

  if_id_reg u_if_id (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (w_flush),
    .i_load  (w_advance),
    .i_pc    (w_pc_next),
    .i_instr (i_instruction),
    .o_pc    (o_if_id_pc),
    .o_instr (o_if_id_instr),
    .o_valid (o_if_id_valid)
  );

  assign o_instr_addr  = r_pc;
  assign o_fetch_fault = r_fault;
  assign o_fetch_count = r_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: two instances (large and 16-word memory) share one
// directed stimulus stream and are checked every cycle against a rule model.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        frz;
  logic        br;
  logic [31:0] ba;

  logic [31:0] o_addr  [2];
  logic [31:0] o_ipc   [2];
  logic [31:0] o_iin   [2];
  logic        o_iv    [2];
  logic        o_fault [2];
  logic [31:0] o_cnt   [2];
  logic [31:0] w_instr [2];

  int n_checks = 0;
  int n_errors = 0;

  // Instruction memory contents: never zero, distinct per word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  assign w_instr[0] = mem_word(o_addr[0]);
  assign w_instr[1] = mem_word(o_addr[1]);

  fetch_stage #(.RESET_PC(32'h0), .MEM_WORDS(32'h4000_0000)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_freeze(frz), .i_branch_taken(br),
    .i_branch_addr(ba), .o_instr_addr(o_addr[0]), .i_instruction(w_instr[0]),
    .o_if_id_pc(o_ipc[0]), .o_if_id_instr(o_iin[0]), .o_if_id_valid(o_iv[0]),
    .o_fetch_fault(o_fault[0]), .o_fetch_count(o_cnt[0]));

  fetch_stage #(.RESET_PC(32'h0), .MEM_WORDS(16)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_freeze(frz), .i_branch_taken(br),
    .i_branch_addr(ba), .o_instr_addr(o_addr[1]), .i_instruction(w_instr[1]),
    .o_if_id_pc(o_ipc[1]), .o_if_id_instr(o_iin[1]), .o_if_id_valid(o_iv[1]),
    .o_fetch_fault(o_fault[1]), .o_fetch_count(o_cnt[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Model state, one slot per instance.
  int unsigned m_words [2] = '{32'h4000_0000, 16};
  logic [31:0] m_pc    [2];
  logic [31:0] m_ipc   [2];
  logic [31:0] m_iin   [2];
  logic        m_iv    [2];
  logic        m_fault [2];
  logic [31:0] m_cnt   [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        m_pc[k] = 32'h0; m_ipc[k] = 0; m_iin[k] = 0; m_iv[k] = 0;
        m_fault[k] = 0; m_cnt[k] = 0;
      end else if (br) begin
        m_pc[k] = {ba[31:2], 2'b00};
        m_ipc[k] = 0; m_iin[k] = 0; m_iv[k] = 0;
      end else if ((m_pc[k] >> 2) >= m_words[k]) begin
        m_ipc[k] = 0; m_iin[k] = 0; m_iv[k] = 0; m_fault[k] = 1;
      end else if (!frz) begin
        m_ipc[k] = m_pc[k] + 4;
        m_iin[k] = mem_word(m_pc[k]);
        m_iv[k]  = 1;
        m_cnt[k] = m_cnt[k] + 1;
        m_pc[k]  = m_pc[k] + 4;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("addr[%0d]", k),  o_addr[k],  m_pc[k]);
      chk($sformatf("ifpc[%0d]", k),  o_ipc[k],   m_ipc[k]);
      chk($sformatf("instr[%0d]", k), o_iin[k],   m_iin[k]);
      chk($sformatf("valid[%0d]", k), {31'b0, o_iv[k]},    {31'b0, m_iv[k]});
      chk($sformatf("fault[%0d]", k), {31'b0, o_fault[k]}, {31'b0, m_fault[k]});
      chk($sformatf("count[%0d]", k), o_cnt[k],   m_cnt[k]);
    end
  end

  // Drive one cycle's inputs, then return at the following falling edge.
  task automatic cyc(input logic r, input logic f, input logic b, input logic [31:0] a);
    rst = r; frz = f; br = b; ba = a;
    @(negedge clk);
  endtask

  initial begin
    rst = 0; frz = 0; br = 0; ba = 0;
    repeat (3) cyc(0, 0, 0, 0);
    chk("rst_addr", o_addr[0], 32'h0);
    chk("rst_valid", {31'b0, o_iv[0]}, 32'h0);
    chk("rst_count", o_cnt[0], 32'h0);

    // Straight-line fetch
    for (int i = 0; i < 4; i++) begin
      chk("t1_addr", o_addr[0], 32'(4 * i));
      cyc(1, 0, 0, 0);
      chk("t1_ifpc", o_ipc[0], 32'(4 * (i + 1)));
    end
    chk("t1_count", o_cnt[0], 32'd4);
    chk("t1_instr", o_iin[0], 32'hFFF3_000C);

    // Freeze at PC=8
    cyc(0, 0, 0, 0);
    repeat (2) cyc(1, 0, 0, 0);
    chk("t2_addr", o_addr[0], 32'h8);
    repeat (2) begin
      cyc(1, 1, 0, 0);
      chk("t2_hold_addr", o_addr[0], 32'h8);
      chk("t2_hold_ifpc", o_ipc[0], 32'h8);
      chk("t2_hold_cnt", o_cnt[0], 32'd2);
    end
    cyc(1, 0, 0, 0);
    chk("t2_rel_addr", o_addr[0], 32'd12);
    chk("t2_rel_cnt", o_cnt[0], 32'd3);

    // Branch with simultaneous freeze, unaligned target
    cyc(1, 1, 1, 32'h0000_0093);
    chk("t3_addr", o_addr[0], 32'h90);
    chk("t3_valid", {31'b0, o_iv[0]}, 32'h0);
    chk("t3_instr", o_iin[0], 32'h0);
    cyc(1, 0, 0, 0);
    chk("t3_cap", o_iin[0], 32'hFF6F_0090);
    chk("t3_ifpc", o_ipc[0], 32'h94);
    chk("t3_b_fault", {31'b0, o_fault[1]}, 32'h1);

    // Run off the end of a 16-word memory
    cyc(0, 0, 0, 0);
    repeat (16) cyc(1, 0, 0, 0);
    chk("t4_addr", o_addr[1], 32'd64);
    chk("t4_last", o_iin[1], 32'hFFC3_003C);
    chk("t4_nofault", {31'b0, o_fault[1]}, 32'h0);
    cyc(1, 0, 0, 0);
    chk("t4_fault", {31'b0, o_fault[1]}, 32'h1);
    chk("t4_hold", o_addr[1], 32'd64);
    chk("t4_valid", {31'b0, o_iv[1]}, 32'h0);
    chk("t4_cnt", o_cnt[1], 32'd16);
    cyc(1, 0, 1, 32'h0);
    chk("t4_br_addr", o_addr[1], 32'h0);
    cyc(1, 0, 0, 0);
    chk("t4_resume", {31'b0, o_iv[1]}, 32'h1);
    chk("t4_sticky", {31'b0, o_fault[1]}, 32'h1);

    // Reset wins over branch and freeze
    cyc(1, 1, 0, 0);
    cyc(0, 1, 1, 32'h40);
    chk("t5_fault", {31'b0, o_fault[1]}, 32'h0);
    chk("t5_cnt", o_cnt[1], 32'h0);
    chk("t5_addr", o_addr[1], 32'h0);
    cyc(1, 0, 0, 0);
    chk("t5_restart", o_addr[0], 32'h4);

    // PC wrap at the top of a 2^30-word memory
    cyc(1, 0, 1, 32'hFFFF_FFFE);
    chk("t6_addr", o_addr[0], 32'hFFFF_FFFC);
    cyc(1, 0, 0, 0);
    chk("t6_wrap", o_addr[0], 32'h0);
    chk("t6_ifpc", o_ipc[0], 32'h0);
    chk("t6_instr", o_iin[0], 32'h0003_FFFC);
    chk("t6_nofault", {31'b0, o_fault[0]}, 32'h0);

    // Mixed freeze/branch traffic, model-checked
    for (int i = 0; i < 24; i++)
      cyc(1, (i % 3) == 1, (i == 9) || (i == 17), (i == 9) ? 32'h20 : 32'h3C);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
